fetch_unit: RTL and testbench

- Upstream neighbour of instruction_memory: owns the program counter and drives the 8-bit byte address `imem_addr` into it.
- Captures the returned 32-bit word into an IF output register and hands it to decode with a valid/ready handshake.
- Handles redirects (branch/jump), backpressure stalls, EBREAK halt, and a misaligned-target trap.

---
 rtl/fetch_unit.sv | 150 +++++++++++++++
 tb/tb_fetch_unit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, drives imem_addr, registers the returned word
// and hands it to decode over valid/ready. Handles redirect, stall,
// EBREAK halt and a sticky misaligned-redirect trap.
// Ports: clk, reset (async high), imem_addr/imem_instr (memory side),
//   out_valid/out_ready/out_instr/out_pc (decode side),
//   redirect_valid/redirect_target, halted, trap.
// Optional: define FETCH_PERF_EN to add fetch_count/flush_count.
module fetch_unit #(
  parameter int                   PC_WIDTH   = 8,
  parameter logic [PC_WIDTH-1:0]  RESET_PC   = '0,
  parameter logic [31:0]          HALT_INSTR = 32'h00100073
) (
  input  logic                clk,
  input  logic                reset,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic [31:0]         imem_instr,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_instr,
  output logic [PC_WIDTH-1:0] out_pc,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_target,
  output logic                halted,
  output logic                trap
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]         fetch_count,
  output logic [15:0]         flush_count
`endif
);

  localparam logic [31:0] NOP = 32'h00000013;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HALT = 2'd1,
    TRAP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                valid_q, valid_d;
  logic [31:0]         instr_q, instr_d;
  logic [PC_WIDTH-1:0] opc_q, opc_d;

  logic adv;
  logic redir_ok;

  assign adv      = !valid_q || out_ready;
  assign redir_ok = (redirect_target[1:0] == 2'b00);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    instr_d = instr_q;
    opc_d   = opc_q;
    unique case (state_q)
      RUN: begin
        if (redirect_valid) begin
          // Flush wins over a same-cycle accept.
          valid_d = 1'b0;
          if (redir_ok) pc_d = redirect_target;
          else          state_d = TRAP;
        end else if (adv) begin
          instr_d = imem_instr;
          opc_d   = pc_q;
          valid_d = 1'b1;
          pc_d    = pc_q + PC_WIDTH'(4);
          if (imem_instr == HALT_INSTR) state_d = HALT;
        end
      end
      HALT: begin
        if (redirect_valid) begin
          valid_d = 1'b0;
          if (redir_ok) begin
            pc_d    = redirect_target;
            state_d = RUN;
          end else begin
            state_d = TRAP;
          end
        end else if (out_ready) begin
          valid_d = 1'b0;
        end
      end
      TRAP: begin
        valid_d = 1'b0;
      end
      default: begin
        state_d = TRAP;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      instr_q <= NOP;
      opc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      opc_q   <= opc_d;
    end
  end

  assign imem_addr = pc_q;
  assign out_valid = valid_q;
  assign out_instr = instr_q;
  assign out_pc    = opc_q;
  assign halted    = (state_q == HALT);
  assign trap      = (state_q == TRAP);

`ifdef FETCH_PERF_EN
  logic [15:0] fcnt_q, fcnt_d;
  logic [15:0] xcnt_q, xcnt_d;
  logic        hs;
  logic        fl;

  // A redirect in the same cycle as ready is a flush, not an accept.
  assign hs = valid_q && out_ready && !redirect_valid;
  assign fl = valid_q && redirect_valid && (state_q != TRAP);

  always_comb begin
    fcnt_d = fcnt_q;
    xcnt_d = xcnt_q;
    if (hs && fcnt_q != 16'hFFFF) fcnt_d = fcnt_q + 16'd1;
    if (fl && xcnt_q != 16'hFFFF) xcnt_d = xcnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fcnt_q <= '0;
      xcnt_q <= '0;
    end else begin
      fcnt_q <= fcnt_d;
      xcnt_q <= xcnt_d;
    end
  end

  assign fetch_count = fcnt_q;
  assign flush_count = xcnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomized-ready stimulus with a
// behavioural fetch model compared every cycle, plus literal checks.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  imem_addr;
  logic [31:0] imem_instr;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic [7:0]  out_pc;
  logic        redirect_valid = 1'b0;
  logic [7:0]  redirect_target = 8'h00;
  logic        halted;
  logic        trap;
`ifdef FETCH_PERF_EN
  logic [15:0] fetch_count;
  logic [15:0] flush_count;
`endif

  logic [31:0] mem [64];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign imem_instr = mem[imem_addr[7:2]];

  fetch_unit dut (
    .clk             (clk),
    .reset           (rst),
    .imem_addr       (imem_addr),
    .imem_instr      (imem_instr),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instr       (out_instr),
    .out_pc          (out_pc),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .halted          (halted),
    .trap            (trap)
`ifdef FETCH_PERF_EN
    ,
    .fetch_count     (fetch_count),
    .flush_count     (flush_count)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model
  logic [7:0]  m_pc;
  logic [7:0]  m_opc;
  logic [31:0] m_instr;
  bit          m_valid, m_halt, m_trap;
  int          m_fetch, m_flush;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc = 8'h00; m_opc = 8'h00; m_instr = 32'h00000013;
      m_valid = 0; m_halt = 0; m_trap = 0;
      m_fetch = 0; m_flush = 0;
    end else if (m_trap) begin
      m_valid = 0;
    end else if (redirect_valid) begin
      if (m_valid) m_flush++;
      m_valid = 0;
      if (redirect_target[1:0] == 2'b00) begin
        m_pc = redirect_target;
        m_halt = 0;
      end else begin
        m_trap = 1;
        m_halt = 0;
      end
    end else begin
      if (m_valid && out_ready) m_fetch++;
      if (m_halt) begin
        if (out_ready) m_valid = 0;
      end else if (!m_valid || out_ready) begin
        m_instr = mem[m_pc[7:2]];
        m_opc   = m_pc;
        m_valid = 1;
        m_pc    = m_pc + 8'd4;
        if (m_instr == 32'h00100073) m_halt = 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("m_imem_addr", {24'd0, imem_addr}, {24'd0, m_pc});
    chk("m_out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    chk("m_out_instr", out_instr, m_instr);
    chk("m_out_pc", {24'd0, out_pc}, {24'd0, m_opc});
    chk("m_halted", {31'd0, halted}, {31'd0, m_halt});
    chk("m_trap", {31'd0, trap}, {31'd0, m_trap});
`ifdef FETCH_PERF_EN
    chk("m_fetch_count", {16'd0, fetch_count}, m_fetch);
    chk("m_flush_count", {16'd0, flush_count}, m_flush);
`endif
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic redir(input logic [7:0] t);
    redirect_valid  = 1'b1;
    redirect_target = t;
    step();
    redirect_valid  = 1'b0;
  endtask

  initial begin
    logic [5:0] w;
    for (int i = 0; i < 64; i++) mem[i] = 32'h00000013;
    mem[1]  = 32'h00100093;
    mem[2]  = 32'h00200113;
    mem[3]  = 32'h002081B3;
    mem[4]  = 32'h00100073;
    mem[63] = 32'h00500293;

    repeat (2) step();
    chk("reset_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_instr", out_instr, 32'h00000013);
    rst = 1'b0;

    step();
    chk("seq_pc0", {24'd0, out_pc}, 32'h00);
    chk("seq_in0", out_instr, 32'h00000013);
    step();
    chk("seq_pc4", {24'd0, out_pc}, 32'h04);
    out_ready = 1'b0;
    repeat (3) begin
      step();
      chk("stall_pc", {24'd0, out_pc}, 32'h04);
      chk("stall_in", out_instr, 32'h00100093);
      chk("stall_addr", {24'd0, imem_addr}, 32'h08);
    end
    out_ready = 1'b1;
    step();
    chk("seq_pc8", {24'd0, out_pc}, 32'h08);
    chk("seq_in8", out_instr, 32'h00200113);
    step();
    chk("seq_pcC", {24'd0, out_pc}, 32'h0C);
    chk("seq_inC", out_instr, 32'h002081B3);
    step();
    chk("halt_pc", {24'd0, out_pc}, 32'h10);
    chk("halt_in", out_instr, 32'h00100073);
    chk("halt_v", {31'd0, out_valid}, 32'd1);
    step();
    chk("halted", {31'd0, halted}, 32'd1);
    chk("halt_nov", {31'd0, out_valid}, 32'd0);
    step();
    chk("halt_nov2", {31'd0, out_valid}, 32'd0);

    redir(8'h00);
    chk("unhalt", {31'd0, halted}, 32'd0);
    step();
    chk("refetch0", {24'd0, out_pc}, 32'h00);
    chk("refetch_v", {31'd0, out_valid}, 32'd1);

    redir(8'h20);
    chk("flush_v", {31'd0, out_valid}, 32'd0);
    step();
    chk("tgt20", {24'd0, out_pc}, 32'h20);

    redir(8'hFC);
    step();
    chk("pcFC", {24'd0, out_pc}, 32'hFC);
    chk("inFC", out_instr, 32'h00500293);
    step();
    chk("wrap00", {24'd0, out_pc}, 32'h00);

    redir(8'h06);
    chk("trap_set", {31'd0, trap}, 32'd1);
    chk("trap_nov", {31'd0, out_valid}, 32'd0);
    step();
    redir(8'h00);
    chk("trap_stick", {31'd0, trap}, 32'd1);
    step();
    chk("trap_nov2", {31'd0, out_valid}, 32'd0);

    rst = 1'b1;
    #1;
    chk("async_trap", {31'd0, trap}, 32'd0);
    chk("async_v", {31'd0, out_valid}, 32'd0);
    chk("async_addr", {24'd0, imem_addr}, 32'h00);
    step();
    rst = 1'b0;

    repeat (6) step();
    chk("perf_halt", {31'd0, halted}, 32'd1);
    redir(8'h00);
    step();
    chk("perf_v", {31'd0, out_valid}, 32'd1);
    redir(8'h00);
    chk("perf_flush_v", {31'd0, out_valid}, 32'd0);
`ifdef FETCH_PERF_EN
    chk("fetch_count5", {16'd0, fetch_count}, 32'd5);
    chk("flush_count1", {16'd0, flush_count}, 32'd1);
`endif

    for (int i = 0; i < 300; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 11) == 0) begin
        w = 6'($urandom_range(0, 63));
        redirect_valid  = 1'b1;
        redirect_target = {w, 2'b00};
      end else begin
        redirect_valid = 1'b0;
      end
      step();
    end
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
